// File: rtl/register_bank_param_if.sv
// Decoder/writeback bus for register_bank_param: read, write, lock, stack-pointer and PC pass-through.
interface register_bank_param_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 3
);
  logic              clk_en;
  logic              w_en;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic [ADDR_W-1:0] ra_addr;
  logic [ADDR_W-1:0] rb_addr;
  logic              read_sp;
  logic [DATA_W-1:0] ra_data;
  logic [DATA_W-1:0] rb_data;
  logic              ra_busy;
  logic              rb_busy;
  logic              lock_en;
  logic [ADDR_W-1:0] lock_addr;
  logic              sp_inc;
  logic              sp_dec;
  logic [DATA_W-1:0] sp_data;
  logic [DATA_W-1:0] pc_in;
  logic [DATA_W-1:0] pc_out;

  modport master (
    output clk_en, w_en, w_addr, w_data, ra_addr, rb_addr, read_sp,
           lock_en, lock_addr, sp_inc, sp_dec, pc_in,
    input  ra_data, rb_data, ra_busy, rb_busy, sp_data, pc_out
  );

  modport slave (
    input  clk_en, w_en, w_addr, w_data, ra_addr, rb_addr, read_sp,
           lock_en, lock_addr, sp_inc, sp_dec, pc_in,
    output ra_data, rb_data, ra_busy, rb_busy, sp_data, pc_out
  );
endinterface

// File: rtl/register_bank_param.sv
// Parametrised register bank: 2R/1W array with write-through bypass, stack pointer and busy scoreboard.
// Optional feature: define ZERO_REG_EN to hard-wire register 0 to zero (never written, never locked).
module register_bank_param #(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       ADDR_W   = 3,
  parameter logic [DATA_W-1:0] SP_RESET = DATA_W'(32'h0000_0FFC),
  parameter int unsigned       SP_STEP  = 4
) (
  input logic                  clk,
  input logic                  rst,
  register_bank_param_if.slave bus
);

  localparam int unsigned       NUM_REGS = 2 ** ADDR_W;
  localparam logic [DATA_W-1:0] STEP     = DATA_W'(SP_STEP);

`ifdef ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_nxt_c;
  logic [DATA_W-1:0]   sp_q;
  logic [DATA_W-1:0]   sp_nxt_c;
  logic                wr_ok_c;
  logic                lock_ok_c;
  logic                ra_zero_c;
  logic                rb_zero_c;
  logic                ra_byp_c;
  logic                rb_byp_c;
  logic                ra_lock_c;
  logic                rb_lock_c;

  // Qualified state updates; index 0 is excluded when it is hard-wired.
  always_comb begin
    wr_ok_c   = bus.clk_en && bus.w_en &&
                !(ZERO_REG && (bus.w_addr == ADDR_W'(0)));
    lock_ok_c = bus.clk_en && bus.lock_en &&
                !(ZERO_REG && (bus.lock_addr == ADDR_W'(0)));
  end

  // Write clears the producer's busy bit; a same-cycle lock re-arms it.
  always_comb begin
    busy_nxt_c = busy_q;
    if (wr_ok_c)   busy_nxt_c[bus.w_addr]    = 1'b0;
    if (lock_ok_c) busy_nxt_c[bus.lock_addr] = 1'b1;
  end

  // Opposing push/pop requests cancel; arithmetic wraps at DATA_W bits.
  always_comb begin
    sp_nxt_c = sp_q;
    if (bus.sp_inc && !bus.sp_dec)      sp_nxt_c = sp_q - STEP;
    else if (bus.sp_dec && !bus.sp_inc) sp_nxt_c = sp_q + STEP;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '{default: '0};
      busy_q <= '0;
      sp_q   <= SP_RESET;
    end else if (bus.clk_en) begin
      if (wr_ok_c) regs_q[bus.w_addr] <= bus.w_data;
      busy_q <= busy_nxt_c;
      sp_q   <= sp_nxt_c;
    end
  end

  // Read-side address decode; bypass follows w_en alone, not clk_en.
  always_comb begin
    ra_zero_c = ZERO_REG && (bus.ra_addr == ADDR_W'(0));
    rb_zero_c = ZERO_REG && (bus.rb_addr == ADDR_W'(0));
    ra_byp_c  = bus.w_en && (bus.ra_addr == bus.w_addr);
    rb_byp_c  = bus.w_en && (bus.rb_addr == bus.w_addr);
    ra_lock_c = bus.lock_en && (bus.lock_addr == bus.ra_addr);
    rb_lock_c = bus.lock_en && (bus.lock_addr == bus.rb_addr);
  end

  always_comb begin
    bus.ra_data = regs_q[bus.ra_addr];
    bus.ra_busy = busy_q[bus.ra_addr];
    if (bus.read_sp) begin
      bus.ra_data = sp_q;
      bus.ra_busy = 1'b0;
    end else if (ra_zero_c) begin
      bus.ra_data = '0;
      bus.ra_busy = 1'b0;
    end else if (ra_byp_c) begin
      bus.ra_data = bus.w_data;
      bus.ra_busy = ra_lock_c;
    end
  end

  always_comb begin
    bus.rb_data = regs_q[bus.rb_addr];
    bus.rb_busy = busy_q[bus.rb_addr];
    if (rb_zero_c) begin
      bus.rb_data = '0;
      bus.rb_busy = 1'b0;
    end else if (rb_byp_c) begin
      bus.rb_data = bus.w_data;
      bus.rb_busy = rb_lock_c;
    end
  end

  assign bus.sp_data = sp_q;
  assign bus.pc_out  = bus.pc_in;

endmodule

// File: tb/tb_register_bank_param.sv
// Directed self-checking bench for register_bank_param (honours ZERO_REG_EN when defined).
module tb_register_bank_param;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  register_bank_param_if #(.DATA_W(32), .ADDR_W(3)) bus ();

  register_bank_param dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.clk_en    = 1'b1;
    bus.w_en      = 1'b0;
    bus.w_addr    = '0;
    bus.w_data    = '0;
    bus.ra_addr   = '0;
    bus.rb_addr   = '0;
    bus.read_sp   = 1'b0;
    bus.lock_en   = 1'b0;
    bus.lock_addr = '0;
    bus.sp_inc    = 1'b0;
    bus.sp_dec    = 1'b0;
    bus.pc_in     = 32'h1000_0040;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) begin
      bus.ra_addr = 3'(i);
      bus.rb_addr = 3'(7 - i);
      #1;
      vectors++;
      if (bus.ra_data !== 32'h0 || bus.rb_data !== 32'h0 ||
          bus.ra_busy !== 1'b0 || bus.rb_busy !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_read[%0d]: ra=%h rb=%h rab=%b rbb=%b, want all 0",
                 i, bus.ra_data, bus.rb_data, bus.ra_busy, bus.rb_busy);
      end
    end
    vectors++;
    if (bus.sp_data !== 32'h0000_0FFC) begin
      miscompares++;
      $display("FAIL reset_sp: got %h want 00000ffc", bus.sp_data);
    end
    vectors++;
    if (bus.pc_out !== 32'h1000_0040) begin
      miscompares++;
      $display("FAIL pc_out: got %h want 10000040", bus.pc_out);
    end
  endtask

  task automatic test_write_bypass();
    bus.w_en = 1'b1; bus.w_addr = 3'd3; bus.w_data = 32'hDEAD_BEEF;
    bus.ra_addr = 3'd3; bus.rb_addr = 3'd4;
    #1;
    vectors++;
    if (bus.ra_data !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL bypass_a: got %h want deadbeef", bus.ra_data);
    end
    vectors++;
    if (bus.rb_data !== 32'h0) begin
      miscompares++;
      $display("FAIL bypass_b_other: got %h want 0", bus.rb_data);
    end
    tick();
    bus.w_en = 1'b0; bus.rb_addr = 3'd3;
    #1;
    vectors++;
    if (bus.ra_data !== 32'hDEAD_BEEF || bus.rb_data !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL array_read3: ra=%h rb=%h want deadbeef", bus.ra_data, bus.rb_data);
    end
  endtask

  task automatic test_clk_en();
    bus.clk_en = 1'b0;
    bus.w_en = 1'b1; bus.w_addr = 3'd5; bus.w_data = 32'h0000_1234;
    bus.lock_en = 1'b1; bus.lock_addr = 3'd6;
    bus.sp_inc = 1'b1;
    bus.ra_addr = 3'd5; bus.rb_addr = 3'd6;
    #1;
    vectors++;
    if (bus.ra_data !== 32'h0000_1234) begin
      miscompares++;
      $display("FAIL gated_bypass: got %h want 00001234", bus.ra_data);
    end
    tick();
    bus.w_en = 1'b0; bus.lock_en = 1'b0; bus.sp_inc = 1'b0;
    bus.clk_en = 1'b1;
    #1;
    vectors++;
    if (bus.ra_data !== 32'h0 || bus.rb_busy !== 1'b0 || bus.sp_data !== 32'h0000_0FFC) begin
      miscompares++;
      $display("FAIL gated_freeze: r5=%h busy6=%b sp=%h want 0 0 00000ffc",
               bus.ra_data, bus.rb_busy, bus.sp_data);
    end
  endtask

  task automatic test_lock();
    bus.lock_en = 1'b1; bus.lock_addr = 3'd2; bus.rb_addr = 3'd2;
    #1;
    vectors++;
    if (bus.rb_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL lock_pre_edge: got %b want 0", bus.rb_busy);
    end
    tick();
    bus.lock_en = 1'b0;
    #1;
    vectors++;
    if (bus.rb_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL lock_set: got %b want 1", bus.rb_busy);
    end
    bus.w_en = 1'b1; bus.w_addr = 3'd2; bus.w_data = 32'd7;
    #1;
    vectors++;
    if (bus.rb_busy !== 1'b0 || bus.rb_data !== 32'd7) begin
      miscompares++;
      $display("FAIL lock_bypass: busy=%b data=%h want 0 00000007", bus.rb_busy, bus.rb_data);
    end
    tick();
    bus.w_en = 1'b0;
    #1;
    vectors++;
    if (bus.rb_busy !== 1'b0 || bus.rb_data !== 32'd7) begin
      miscompares++;
      $display("FAIL write_clears_busy: busy=%b data=%h want 0 00000007", bus.rb_busy, bus.rb_data);
    end
    bus.w_en = 1'b1; bus.w_data = 32'd9;
    bus.lock_en = 1'b1; bus.lock_addr = 3'd2;
    #1;
    vectors++;
    if (bus.rb_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL lock_write_bypass_busy: got %b want 1", bus.rb_busy);
    end
    tick();
    bus.w_en = 1'b0; bus.lock_en = 1'b0;
    #1;
    vectors++;
    if (bus.rb_busy !== 1'b1 || bus.rb_data !== 32'd9) begin
      miscompares++;
      $display("FAIL lock_wins: busy=%b data=%h want 1 00000009", bus.rb_busy, bus.rb_data);
    end
  endtask

  task automatic test_sp();
    bus.sp_inc = 1'b1;
    #1;
    vectors++;
    if (bus.sp_data !== 32'h0000_0FFC) begin
      miscompares++;
      $display("FAIL sp_no_bypass: got %h want 00000ffc", bus.sp_data);
    end
    repeat (3) tick();
    vectors++;
    if (bus.sp_data !== 32'h0000_0FF0) begin
      miscompares++;
      $display("FAIL sp_push3: got %h want 00000ff0", bus.sp_data);
    end
    bus.sp_dec = 1'b1;
    tick();
    vectors++;
    if (bus.sp_data !== 32'h0000_0FF0) begin
      miscompares++;
      $display("FAIL sp_both: got %h want 00000ff0", bus.sp_data);
    end
    bus.sp_inc = 1'b0;
    tick();
    vectors++;
    if (bus.sp_data !== 32'h0000_0FF4) begin
      miscompares++;
      $display("FAIL sp_pop: got %h want 00000ff4", bus.sp_data);
    end
    bus.sp_dec = 1'b0; bus.sp_inc = 1'b1;
    repeat (1021) tick();
    vectors++;
    if (bus.sp_data !== 32'h0) begin
      miscompares++;
      $display("FAIL sp_to_zero: got %h want 0", bus.sp_data);
    end
    tick();
    bus.sp_inc = 1'b0;
    #1;
    vectors++;
    if (bus.sp_data !== 32'hFFFF_FFFC) begin
      miscompares++;
      $display("FAIL sp_wrap: got %h want fffffffc", bus.sp_data);
    end
  endtask

  task automatic test_read_sp();
    bus.read_sp = 1'b1; bus.ra_addr = 3'd2;
    bus.w_en = 1'b1; bus.w_addr = 3'd2; bus.w_data = 32'h5555_AAAA;
    #1;
    vectors++;
    if (bus.ra_data !== 32'hFFFF_FFFC || bus.ra_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL read_sp: data=%h busy=%b want fffffffc 0", bus.ra_data, bus.ra_busy);
    end
    bus.w_en = 1'b0; bus.read_sp = 1'b0;
    #1;
    vectors++;
    if (bus.ra_data !== 32'd9 || bus.ra_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL read_sp_off: data=%h busy=%b want 00000009 1", bus.ra_data, bus.ra_busy);
    end
  endtask

  task automatic test_zero_reg();
    logic [31:0] exp_data;
    logic        exp_busy;
`ifdef ZERO_REG_EN
    exp_data = 32'h0;
    exp_busy = 1'b0;
`else
    exp_data = 32'h0000_00FF;
    exp_busy = 1'b1;
`endif
    bus.w_en = 1'b1; bus.w_addr = 3'd0; bus.w_data = 32'h0000_00FF;
    bus.ra_addr = 3'd0; bus.rb_addr = 3'd0;
    #1;
    vectors++;
    if (bus.ra_data !== exp_data || bus.rb_data !== exp_data) begin
      miscompares++;
      $display("FAIL zero_bypass: ra=%h rb=%h want %h", bus.ra_data, bus.rb_data, exp_data);
    end
    tick();
    bus.w_en = 1'b0;
    bus.lock_en = 1'b1; bus.lock_addr = 3'd0;
    tick();
    bus.lock_en = 1'b0;
    #1;
    vectors++;
    if (bus.ra_data !== exp_data || bus.rb_busy !== exp_busy || bus.ra_busy !== exp_busy) begin
      miscompares++;
      $display("FAIL zero_reg: data=%h rab=%b rbb=%b want %h %b", bus.ra_data,
               bus.ra_busy, bus.rb_busy, exp_data, exp_busy);
    end
  endtask

  task automatic test_reset_discard();
    bus.w_en = 1'b1; bus.w_addr = 3'd4; bus.w_data = 32'h0000_0055;
    bus.lock_en = 1'b1; bus.lock_addr = 3'd4;
    bus.sp_inc = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle_inputs();
    bus.ra_addr = 3'd4; bus.rb_addr = 3'd3;
    #1;
    vectors++;
    if (bus.ra_data !== 32'h0 || bus.ra_busy !== 1'b0 || bus.rb_data !== 32'h0 ||
        bus.sp_data !== 32'h0000_0FFC) begin
      miscompares++;
      $display("FAIL reset_discard: r4=%h b4=%b r3=%h sp=%h want 0 0 0 00000ffc",
               bus.ra_data, bus.ra_busy, bus.rb_data, bus.sp_data);
    end
    bus.rb_addr = 3'd2;
    #1;
    vectors++;
    if (bus.rb_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_busy2: got %b want 0", bus.rb_busy);
    end
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    test_reset();
    test_write_bypass();
    test_clk_en();
    test_lock();
    test_sp();
    test_read_sp();
    test_zero_reg();
    test_reset_discard();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
